// File: rtl/alu_seq_defs.sv
// Shared encodings for the ALU operation sequencer: command classes, ALU
// selects, FSM states and the bit positions of every command field.
package alu_seq_defs;

  localparam int ALU_W    = 4;
  localparam int NUM_REGS = 4;
  localparam int INSTR_W  = 10;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOADI = 2'b01;
  localparam logic [1:0] CLS_READ  = 2'b10;
  localparam logic [1:0] CLS_NOP   = 2'b11;

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_XOR = 2'b10;
  localparam logic [1:0] SEL_ADD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // READ reuses the rs1 field position for its source register.
  localparam int CLS_HI = 9;
  localparam int CLS_LO = 8;
  localparam int SEL_HI = 7;
  localparam int SEL_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int RS1_HI = 3;
  localparam int RS1_LO = 2;
  localparam int RS2_HI = 1;
  localparam int RS2_LO = 0;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Combinational 4-bit ALU: AND/OR/XOR clear carry, ADD reports carry-out.
module alu_op_sequencer_alu
  import alu_seq_defs::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [1:0]       sel_i,
  output logic [ALU_W-1:0] out_o,
  output logic             carry_o
);

  logic [ALU_W:0] sum;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    out_o   = '0;
    carry_o = 1'b0;
    case (sel_i)
      SEL_AND: out_o = a_i & b_i;
      SEL_OR:  out_o = a_i | b_i;
      SEL_XOR: out_o = a_i ^ b_i;
      SEL_ADD: begin
        out_o   = sum[ALU_W-1:0];
        carry_o = sum[ALU_W];
      end
      default: out_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Executes ALU/LOADI/READ/NOP commands one at a time against a 4-entry
// register file with carry/zero flags; READ results leave via a response handshake.
module alu_op_sequencer
  import alu_seq_defs::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [INSTR_W-1:0] cmd_instr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic [DATA_W-1:0]  rspData_q, rspData_d;
  logic               rspCarry_q, rspCarry_d;
  logic               rspZero_q, rspZero_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [1:0]         cls, sel, rd, rs1, rs2;
  logic [DATA_W-1:0]  imm, aluA, aluB, aluOut;
  logic               aluCarry;

  assign cls = instr_q[CLS_HI:CLS_LO];
  assign sel = instr_q[SEL_HI:SEL_LO];
  assign rd  = instr_q[RD_HI:RD_LO];
  assign rs1 = instr_q[RS1_HI:RS1_LO];
  assign rs2 = instr_q[RS2_HI:RS2_LO];
  assign imm = instr_q[IMM_HI:IMM_LO];

  // Operands are held at zero outside EXEC so the ALU only toggles when used.
  assign aluA = (state_q == ST_EXEC) ? regs_q[rs1] : '0;
  assign aluB = (state_q == ST_EXEC) ? regs_q[rs2] : '0;

  alu_op_sequencer_alu u_alu (
    .a_i    (aluA),
    .b_i    (aluB),
    .sel_i  (sel),
    .out_o  (aluOut),
    .carry_o(aluCarry)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_data  = rspData_q;
  assign rsp_carry = rspCarry_q;
  assign rsp_zero  = rspZero_q;
  assign op_count  = count_q;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    regs_d     = regs_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    rspData_d  = rspData_q;
    rspCarry_d = rspCarry_q;
    rspZero_d  = rspZero_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          instr_d = cmd_instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (cls)
          CLS_ALU: begin
            regs_d[rd] = aluOut;
            carry_d    = aluCarry;
            zero_d     = (aluOut == '0);
            count_d    = count_q + CNT_W'(1);
          end
          CLS_LOADI: begin
            regs_d[rd] = imm;
            zero_d     = (imm == '0);
            count_d    = count_q + CNT_W'(1);
          end
          CLS_READ: begin
            rspData_d  = regs_q[rs1];
            rspCarry_d = carry_q;
            rspZero_d  = zero_q;
            state_d    = ST_RESP;
          end
          CLS_NOP: count_d = count_q + CNT_W'(1);
        endcase
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset discards any in-flight command or pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      rspData_q  <= '0;
      rspCarry_q <= 1'b0;
      rspZero_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      regs_q     <= regs_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      rspData_q  <= rspData_d;
      rspCarry_q <= rspCarry_d;
      rspZero_q  <= rspZero_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer, checked against a
// command-level model of the register file, flags and retired-command count.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_instr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       busy;
  logic [7:0] op_count;

  int checkCount = 0;
  int passCount  = 0;

  int mRegs[4];
  int mCarry;
  int mZero;
  int mCount;

  alu_op_sequencer #(.DATA_W(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_instr(cmd_instr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_carry(rsp_carry),
    .rsp_zero (rsp_zero),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  function automatic logic [9:0] mkAlu(input logic [1:0] sel, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2);
    return {2'b00, sel, rd, rs1, rs2};
  endfunction

  function automatic logic [9:0] mkLoadi(input logic [1:0] rd, input logic [3:0] imm);
    logic [1:0] junk;
    junk = 2'($urandom);
    return {2'b01, junk, rd, imm};
  endfunction

  function automatic logic [9:0] mkRead(input logic [1:0] rs);
    logic [3:0] junkHi;
    logic [1:0] junkLo;
    junkHi = 4'($urandom);
    junkLo = 2'($urandom);
    return {2'b10, junkHi, rs, junkLo};
  endfunction

  function automatic logic [9:0] mkNop();
    logic [7:0] junk;
    junk = 8'($urandom);
    return {2'b11, junk};
  endfunction

  // Command-level model: ADD is plain integer addition split into a 4-bit result and carry.
  task automatic modelApply(input logic [9:0] instr);
    int a, b, res, rd;
    rd = int'(instr[5:4]);
    case (instr[9:8])
      2'b00: begin
        a = mRegs[instr[3:2]];
        b = mRegs[instr[1:0]];
        mCarry = 0;
        case (instr[7:6])
          2'b00: res = a & b;
          2'b01: res = a | b;
          2'b10: res = a ^ b;
          default: begin
            res    = (a + b) % 16;
            mCarry = ((a + b) >= 16) ? 1 : 0;
          end
        endcase
        mRegs[rd] = res;
        mZero     = (res == 0) ? 1 : 0;
        mCount    = (mCount + 1) % 256;
      end
      2'b01: begin
        mRegs[rd] = int'(instr[3:0]);
        mZero     = (instr[3:0] == 4'd0) ? 1 : 0;
        mCount    = (mCount + 1) % 256;
      end
      2'b11: mCount = (mCount + 1) % 256;
      default: ;
    endcase
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) mRegs[i] = 0;
    mCarry = 0;
    mZero  = 0;
    mCount = 0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst       = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  // Presents one command and returns just after the accepting edge (DUT in EXEC).
  task automatic applyStimulus(input logic [9:0] instr);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmdReadyWait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_instr = instr;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_instr = 10'($urandom);
    modelApply(instr);
  endtask

  // A stalled READ also presents a stray command that must not be consumed.
  task automatic doRead(input logic [1:0] rs, input int stall,
                        output logic [3:0] d, output logic c, output logic z);
    int n, expD, expC, expZ;
    expD = mRegs[rs];
    expC = mCarry;
    expZ = mZero;
    applyStimulus(mkRead(rs));
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rspValid", 32'(rsp_valid), 32'd1);
    d = rsp_data;
    c = rsp_carry;
    z = rsp_zero;
    checkOutput("rspData", 32'(rsp_data), 32'(expD));
    checkOutput("rspCarry", 32'(rsp_carry), 32'(expC));
    checkOutput("rspZero", 32'(rsp_zero), 32'(expZ));
    if (stall > 0) begin
      cmd_valid = 1'b1;
      cmd_instr = mkLoadi(rs, 4'(~expD));
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("holdValid", 32'(rsp_valid), 32'd1);
      checkOutput("holdData", 32'(rsp_data), 32'(expD));
      checkOutput("holdCmdReady", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    mCount = (mCount + 1) % 256;
    @(negedge clk);
    checkOutput("postRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("postBusy", 32'(busy), 32'd0);
    checkOutput("opCount", 32'(op_count), 32'(mCount));
  endtask

  initial begin
    logic [3:0] d;
    logic       c, z;
    logic [9:0] list[6];
    int         idx, cyc, lastAcc, countBefore, pick;
    bit         accepted;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_instr = '0;
    rsp_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstCmdReady", 32'(cmd_ready), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstOpCount", 32'(op_count), 32'd0);
    checkOutput("rstRspData", 32'(rsp_data), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("postRstCmdReady", 32'(cmd_ready), 32'd1);

    // ADD with carry-out: 9 + 8
    applyStimulus(mkLoadi(2'd0, 4'd9));
    applyStimulus(mkLoadi(2'd1, 4'd8));
    applyStimulus(mkAlu(2'b11, 2'd2, 2'd0, 2'd1));
    doRead(2'd2, 0, d, c, z);
    checkOutput("addData", 32'(d), 32'd1);
    checkOutput("addCarry", 32'(c), 32'd1);
    checkOutput("addZero", 32'(z), 32'd0);
    checkOutput("addOpCount", 32'(op_count), 32'd4);

    // Logic ops clear carry
    applyStimulus(mkLoadi(2'd0, 4'hC));
    applyStimulus(mkLoadi(2'd1, 4'hA));
    applyStimulus(mkAlu(2'b00, 2'd2, 2'd0, 2'd1));
    doRead(2'd2, 1, d, c, z);
    checkOutput("andData", 32'(d), 32'h8);
    checkOutput("andCarry", 32'(c), 32'd0);
    applyStimulus(mkAlu(2'b01, 2'd2, 2'd0, 2'd1));
    doRead(2'd2, 0, d, c, z);
    checkOutput("orData", 32'(d), 32'hE);
    checkOutput("orCarry", 32'(c), 32'd0);
    applyStimulus(mkAlu(2'b10, 2'd2, 2'd0, 2'd1));
    doRead(2'd2, 2, d, c, z);
    checkOutput("xorData", 32'(d), 32'h6);
    checkOutput("xorCarry", 32'(c), 32'd0);

    // Self-XOR gives zero; LOADI keeps a carry left by an ADD
    applyStimulus(mkAlu(2'b10, 2'd3, 2'd1, 2'd1));
    doRead(2'd3, 0, d, c, z);
    checkOutput("selfXorData", 32'(d), 32'd0);
    checkOutput("selfXorZero", 32'(z), 32'd1);
    applyStimulus(mkLoadi(2'd0, 4'hF));
    applyStimulus(mkLoadi(2'd1, 4'h1));
    applyStimulus(mkAlu(2'b11, 2'd2, 2'd0, 2'd1));
    applyStimulus(mkLoadi(2'd3, 4'd0));
    doRead(2'd3, 0, d, c, z);
    checkOutput("loadiKeepsCarry", 32'(c), 32'd1);
    checkOutput("loadiZero", 32'(z), 32'd1);

    // Long back-pressure on a READ
    doRead(2'd0, 5, d, c, z);
    checkOutput("stallData", 32'(d), 32'hF);

    // cmd_valid held high across six ALU commands
    for (int i = 0; i < 6; i++)
      list[i] = mkAlu(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    countBefore = mCount;
    idx = 0;
    cyc = 0;
    lastAcc = -1;
    @(negedge clk);
    while (!cmd_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    cyc = 0;
    cmd_valid = 1'b1;
    cmd_instr = list[0];
    while (idx < 6 && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      accepted = cmd_ready;
      if (accepted) begin
        if (idx > 0) checkOutput("b2bGap", 32'(cyc - lastAcc), 32'd2);
        lastAcc = cyc;
      end
      @(posedge clk);
      #1;
      if (accepted) begin
        modelApply(list[idx]);
        idx++;
        if (idx < 6) cmd_instr = list[idx];
        else cmd_valid = 1'b0;
      end
      cyc++;
    end
    cmd_valid = 1'b0;
    checkOutput("b2bAccepted", 32'(idx), 32'd6);
    @(posedge clk);
    #1;
    checkOutput("b2bOpCount", 32'(op_count), 32'((countBefore + 6) % 256));
    for (int r = 0; r < 4; r++) doRead(2'(r), 0, d, c, z);

    // Reset while in EXEC
    applyStimulus(mkLoadi(2'd1, 4'd5));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    checkOutput("rstExecRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstExecBusy", 32'(busy), 32'd0);
    checkOutput("rstExecOpCount", 32'(op_count), 32'd0);

    // Reset while in RESP
    applyStimulus(mkLoadi(2'd2, 4'd7));
    applyStimulus(mkRead(2'd2));
    repeat (2) @(negedge clk);
    checkOutput("preRstRespValid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    checkOutput("rstRespRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstRespBusy", 32'(busy), 32'd0);
    checkOutput("rstRespOpCount", 32'(op_count), 32'd0);
    for (int r = 0; r < 4; r++) begin
      doRead(2'(r), 0, d, c, z);
      checkOutput("postRstReg", 32'(d), 32'd0);
    end

    // Randomized command mix
    for (int i = 0; i < 200; i++) begin
      pick = $urandom_range(0, 9);
      if (pick <= 3)
        applyStimulus(mkAlu(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom)));
      else if (pick <= 5)
        applyStimulus(mkLoadi(2'($urandom), 4'($urandom)));
      else if (pick == 8)
        applyStimulus(mkNop());
      else
        doRead(2'($urandom), $urandom_range(0, 3), d, c, z);
    end

    // Counter wrap after 256 NOPs
    resetDut();
    for (int i = 0; i < 256; i++) applyStimulus(mkNop());
    @(posedge clk);
    #1;
    checkOutput("wrapOpCount", 32'(op_count), 32'd0);
    checkOutput("wrapModel", 32'(op_count), 32'(mCount));
    checkOutput("wrapBusy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
